// File: rtl/writeback_arbiter_if.sv
// Writeback bus bundle: ALU/LSU result sources in, register-file write port out.
// Optional forwarding ports are present only when WB_FORWARD_EN is defined.
interface writeback_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [31:0]   lsu_data;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic          reg_write;
  logic [CW-1:0] fifo_count;
`ifdef WB_FORWARD_EN
  logic [4:0]    fwd_rs1;
  logic [4:0]    fwd_rs2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [31:0]   fwd_data1;
  logic [31:0]   fwd_data2;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_rs1, fwd_rs2,
    input  lsu_ready, write_reg, write_data, reg_write, fifo_count,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_rs1, fwd_rs2,
    output lsu_ready, write_reg, write_data, reg_write, fifo_count,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, write_reg, write_data, reg_write, fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, write_reg, write_data, reg_write, fifo_count
  );
`endif
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU has priority on the single register-file write port;
// LSU results that lose arbitration wait in an in-order skid FIFO and drain
// when the ALU is idle. A younger ALU write squashes buffered loads to the
// same rd so the stale load never overwrites it.
// Optional feature macro: WB_FORWARD_EN (decode-stage forwarding of the
// registered write).
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                reset,
  writeback_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_sq;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic             full;
  logic             empty;
  logic             lsu_xfer;
  logic             alu_issue;
  logic             pop;
  logic             bypass;
  logic             push;
  logic             push_sq;

  logic             issue;
  logic [4:0]       issue_rd;
  logic [31:0]      issue_data;

  logic             reg_write_q;
  logic [4:0]       write_reg_q;
  logic [31:0]      write_data_q;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign lsu_xfer  = bus.lsu_valid && !full;
  assign alu_issue = bus.alu_valid && (bus.alu_rd != 5'd0);
  // rd == 0 transfers are accepted and dropped: neither bypassed nor pushed.
  assign pop       = !alu_issue && !empty;
  assign bypass    = !alu_issue && empty && lsu_xfer && (bus.lsu_rd != 5'd0);
  assign push      = lsu_xfer && (bus.lsu_rd != 5'd0) && !bypass;
  // The ALU write is younger than a same-cycle LSU transfer to the same rd.
  assign push_sq   = alu_issue && (bus.lsu_rd == bus.alu_rd);

  // Select the write issued this cycle: ALU, then FIFO head, then LSU bypass.
  always_comb begin
    issue      = 1'b0;
    issue_rd   = bus.alu_rd;
    issue_data = bus.alu_data;
    if (alu_issue) begin
      issue = 1'b1;
    end else if (pop) begin
      issue      = !fifo_sq[rd_ptr];
      issue_rd   = fifo_rd[rd_ptr];
      issue_data = fifo_data[rd_ptr];
    end else if (bypass) begin
      issue      = 1'b1;
      issue_rd   = bus.lsu_rd;
      issue_data = bus.lsu_data;
    end
  end

  // FIFO storage and squash marking; stale slots are harmless since push rewrites them.
  always_ff @(posedge clk) begin
    if (alu_issue) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_rd[i] == bus.alu_rd) fifo_sq[i] <= 1'b1;
      end
    end
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lsu_rd;
      fifo_data[wr_ptr] <= bus.lsu_data;
      fifo_sq[wr_ptr]   <= push_sq;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; address/data hold when nothing issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      reg_write_q <= issue;
      if (issue) begin
        write_reg_q  <= issue_rd;
        write_data_q <= issue_data;
      end
    end
  end

  assign bus.lsu_ready  = !full;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.fifo_count = count;

`ifdef WB_FORWARD_EN
  assign bus.fwd_hit1  = reg_write_q && (bus.fwd_rs1 == write_reg_q) && (bus.fwd_rs1 != 5'd0);
  assign bus.fwd_hit2  = reg_write_q && (bus.fwd_rs2 == write_reg_q) && (bus.fwd_rs2 != 5'd0);
  assign bus.fwd_data1 = write_data_q;
  assign bus.fwd_data2 = write_data_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed stimulus pushes expected
// writes in output order; a negedge monitor pops one per observed reg_write.
module tb_writeback_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [36:0] exp_q[$];

  writeback_arbiter_if #(.DEPTH(4)) bus ();

  writeback_arbiter #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (bus.reg_write === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%h want no write", bus.write_reg, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.write_reg, bus.write_data} !== e) begin
          bad++;
          $display("FAIL write_order: got rd=%0d data=%h want rd=%0d data=%h",
                   bus.write_reg, bus.write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
`ifdef WB_FORWARD_EN
    bus.fwd_rs1 = 5'd0;
    bus.fwd_rs2 = 5'd0;
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_write_reg", 32'(bus.write_reg), 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);

    // ALU only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    chk("alu_reg_write", 32'(bus.reg_write), 32'd1);
    idle();
    tick();
    chk("alu_deassert", 32'(bus.reg_write), 32'd0);
    chk("hold_write_reg", 32'(bus.write_reg), 32'd5);
    chk("hold_write_data", bus.write_data, 32'hDEADBEEF);

    // ALU vs LSU conflict
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h11);
    expect_wr(5'd3, 32'h33);
    expect_wr(5'd4, 32'h11);
    tick();
    chk("conf_count1", 32'(bus.fifo_count), 32'd1);
    idle();
    tick();
    chk("conf_count0", 32'(bus.fifo_count), 32'd0);
    chk("conf_drain_wr", 32'(bus.reg_write), 32'd1);
    tick();
    chk("conf_idle", 32'(bus.reg_write), 32'd0);

    // Full FIFO
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
      expect_wr(5'(10 + i), 32'hA0 + 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h100 + 32'(i));
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_ready", 32'(bus.lsu_ready), 32'd0);
    idle();
    tick();
    chk("pop1_count", 32'(bus.fifo_count), 32'd3);
    chk("pop1_ready", 32'(bus.lsu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_wr", 32'(bus.reg_write), 32'd1);
    end
    chk("drain_count", 32'(bus.fifo_count), 32'd0);
    tick();
    chk("drain_idle", 32'(bus.reg_write), 32'd0);

    // Squash of a buffered entry
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 32'hAA);
    expect_wr(5'd8, 32'h88);
    tick();
    chk("sq_count1", 32'(bus.fifo_count), 32'd1);
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd7, 32'hBB);
    tick();
    chk("sq_count_hold", 32'(bus.fifo_count), 32'd1);
    idle();
    tick();
    chk("sq_drain_nowr", 32'(bus.reg_write), 32'd0);
    chk("sq_drain_count", 32'(bus.fifo_count), 32'd0);

    // Squash of a same-cycle push
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77);
    expect_wr(5'd6, 32'h66);
    tick();
    chk("sqp_count1", 32'(bus.fifo_count), 32'd1);
    idle();
    tick();
    chk("sqp_nowr", 32'(bus.reg_write), 32'd0);
    chk("sqp_count0", 32'(bus.fifo_count), 32'd0);

    // rd == 0 handling
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    tick();
    chk("rd0_nowr", 32'(bus.reg_write), 32'd0);
    chk("rd0_count", 32'(bus.fifo_count), 32'd0);
    drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd2, 32'h22);
    expect_wr(5'd2, 32'h22);
    tick();
    chk("bypass_wr", 32'(bus.reg_write), 32'd1);
    chk("bypass_count", 32'(bus.fifo_count), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 1'b1, 5'(i + 1), 32'h200 + 32'(i));
      expect_wr(5'(20 + i), 32'hC0 + 32'(i));
      tick();
    end
    chk("mid_count3", 32'(bus.fifo_count), 32'd3);
    idle();
    reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_rst_wr", 32'(bus.reg_write), 32'd0);
    chk("mid_rst_ready", 32'(bus.lsu_ready), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_after_count", 32'(bus.fifo_count), 32'd0);

`ifdef WB_FORWARD_EN
    drive(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd9, 32'h12345678);
    tick();
    idle();
    bus.fwd_rs1 = 5'd9;
    bus.fwd_rs2 = 5'd0;
    #1;
    chk("fwd_hit1", 32'(bus.fwd_hit1), 32'd1);
    chk("fwd_data1", bus.fwd_data1, 32'h12345678);
    chk("fwd_hit2", 32'(bus.fwd_hit2), 32'd0);
    bus.fwd_rs1 = 5'd0;
    tick();
`endif

    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that drives the register file's single write port (write_reg, write_data, reg_write) from two result sources: the single-cycle ALU and the variable-latency load/store unit (LSU). The ALU always has priority. LSU results that lose arbitration are held in a small in-order skid FIFO and drained on cycles when the ALU is idle. All register-file write outputs are registered.

## Interface
- DEPTH, 4: LSU skid FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH+1): width of the occupancy count.

Ports (single clock domain, reset synchronous active-high):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the FIFO and all outputs.
- alu_valid  in  1  ALU result present; always accepted, no ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  accept; equals !full (combinational from state only).
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  load result.
- write_reg  out  5  register-file write address.
- write_data  out  32  register-file write data.
- reg_write  out  1  register-file write enable.
- fifo_count  out  CW  current FIFO occupancy.

## Operation
- LSU transfer occurs when lsu_valid && lsu_ready.
- Any request with rd == 0 is accepted and discarded. It is never written or buffered.
- Priority order each cycle:
  1. ALU valid with rd != 0: issue the ALU write.
  2. Otherwise, FIFO non-empty: pop the head and issue its write unless the head is squashed.
  3. Otherwise, an LSU transfer with an empty FIFO bypasses the FIFO and is issued directly.
- If an LSU transfer is not issued in the cycle it arrives, it is pushed into the FIFO. FIFO order is strict FIFO.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- lsu_ready = 0 when count == DEPTH. There is no push-through-pop while full.
- Squash rule: an ALU write is younger than all buffered loads and any same-cycle LSU transfer.
  - An ALU write with rd = R sets the squash bit on every FIFO entry with rd == R.
  - It also sets the squash bit on a same-cycle pushed entry with rd == R.
  - A squashed entry is popped normally, but the cycle produces reg_write = 0.
- Pointers wrap modulo DEPTH. fifo_count is 0..DEPTH.

## Timing
- Reset values: reg_write = 0, write_reg = 0, write_data = 0, fifo_count = 0, lsu_ready = 1 (the cycle after reset deasserts).
- Reset asserted mid-operation discards all buffered entries with no writes issued. Outputs are zero in the following cycle.
- Latency: a request issued in cycle N appears on write_reg/write_data/reg_write in cycle N+1 for exactly one cycle.
- reg_write deasserts in any cycle with no issue. write_reg/write_data hold their last values (they are not cleared).
- Throughput: one write per cycle. A buffered load waits at most until the first cycle without alu_valid.
- Back-to-back ALU valids with a full FIFO hold lsu_ready low indefinitely. This is intended.

## Configuration
- WB_FORWARD_EN defined: adds the following ports.
  - fwd_rs1 in 5, fwd_rs2 in 5: source registers to check.
  - fwd_hit1 out 1, fwd_hit2 out 1, fwd_data1 out 32, fwd_data2 out 32.
  - Hit is combinational: the source reg equals the registered write_reg, reg_write = 1, and the source reg != 0. fwd_data is write_data.
  - Used by decode to bypass the register file's same-cycle write.
- WB_FORWARD_EN undefined: these ports and their logic are absent. Everything else is identical.

## Test plan
- ALU only, ALU-priority conflict:
  - alu_valid, rd = 5, data = 0xDEADBEEF in cycle 0 → cycle 1 reg_write = 1, write_reg = 5, write_data = 0xDEADBEEF; cycle 2 reg_write = 0.
  - ALU rd = 3 and LSU rd = 4 (0x11) in cycle 0; ALU idle in cycle 1 → cycle 1 writes r3; cycle 2 writes r4 = 0x11; fifo_count 1 then 0.
- Full FIFO:
  - ALU held valid; 4 LSU pushes with rd 1..4 → fifo_count = 4, lsu_ready = 0.
  - ALU drops → r1..r4 are written in order on four consecutive cycles, and lsu_ready = 1 after the first pop.
- Squash:
  - Buffer an LSU entry rd = 7 (0xAA), then ALU rd = 7 (0xBB) → r7 = 0xBB is written once.
  - The drain cycle for the rd = 7 entry shows reg_write = 0 and fifo_count decrements.
- rd = 0 / reset:
  - LSU rd = 0 → accepted, no push, no write.
  - reset asserted with fifo_count = 3 → next cycle fifo_count = 0, reg_write = 0, and no buffered write ever appears.
- WB_FORWARD_EN:
  - ALU rd = 9 issued; next cycle fwd_rs1 = 9, fwd_rs2 = 0 → fwd_hit1 = 1 with the data, fwd_hit2 = 0.
